// File: rtl/la_bec_loader.sv
// Bridge from the management-core LA bank to the BEC point-multiplication core.
// It loads operands word by word, starts the core, captures its results and reads them back.
module la_bec_loader #(
   parameter int M = 163,
   parameter int W = 32
) (
   input  logic         clock,
   input  logic         resetb,
   input  logic [63:0]  la_data_in,
   input  logic [63:0]  la_oenb,
   output logic [63:0]  la_data_out,
   output logic [M-1:0] bec_w1,
   output logic [M-1:0] bec_z1,
   output logic [M-1:0] bec_w2,
   output logic [M-1:0] bec_z2,
   output logic [M-1:0] bec_inv_w0,
   output logic [M-1:0] bec_d,
   output logic [M-1:0] bec_key,
   output logic         bec_start,
   input  logic         bec_done,
   input  logic [M-1:0] bec_wout,
   input  logic [M-1:0] bec_zout
);
   // state | meaning
   // IDLE  | operands loadable, bec_done ignored
   // RUN   | core running, waiting for bec_done
   // DONE  | results captured and readable

   localparam int NW = (M + W - 1) / W;
   localparam logic [1:0] CMD_NOP   = 2'b00;
   localparam logic [1:0] CMD_WRITE = 2'b01;
   localparam logic [1:0] CMD_START = 2'b10;
   localparam logic [1:0] CMD_READ  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic           req_s1, req_s2, req_s3;
   logic           ack_q, err_q, start_q;
   logic [W-1:0]   rdata_q;
   logic [M-1:0]   op_q [7];
   logic [M-1:0]   res_w_q, res_z_q;

   logic [1:0]     cmd;
   logic [2:0]     op_sel, word_idx;
   logic [W-1:0]   wdata;
   logic           cmd_vld, cmd_err, idx_bad;
   logic           nop_go, wr_go, start_go, rd_go, capture;
   logic           busy, done_flag;
   logic [M-1:0]   op_cur, wr_val, res_sel;
   logic [W-1:0]   rd_words [NW];
   logic [W-1:0]   rd_word;
   logic           unused_la;

   assign wdata    = la_data_in[W-1:0];
   assign op_sel   = la_data_in[34:32];
   assign word_idx = la_data_in[37:35];
   assign cmd      = la_data_in[39:38];
   assign unused_la = ^{la_data_in[63:41], la_oenb[63:41], la_oenb[39:0]};

   // Fields are sampled raw at the execute edge; firmware holds them until ack.
   assign cmd_vld = (req_s2 ^ req_s3) & ~la_oenb[40];
   assign idx_bad = (word_idx >= 3'(NW));

   always_comb begin
      cmd_err = 1'b0;
      case (cmd)
         CMD_WRITE: cmd_err = (op_sel > 3'd6) | idx_bad | (state_q == S_RUN);
         CMD_START: cmd_err = (state_q == S_RUN);
         CMD_READ:  cmd_err = (op_sel > 3'd1) | idx_bad | (state_q == S_RUN);
         default:   cmd_err = 1'b0;
      endcase
   end

   assign nop_go   = cmd_vld & (cmd == CMD_NOP);
   assign wr_go    = cmd_vld & (cmd == CMD_WRITE) & ~cmd_err;
   assign start_go = cmd_vld & (cmd == CMD_START) & ~cmd_err;
   assign rd_go    = cmd_vld & (cmd == CMD_READ) & ~cmd_err;
   assign capture  = (state_q == S_RUN) & bec_done;

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start_go) state_d = S_RUN;
         S_RUN:  if (bec_done) state_d = S_DONE;
         S_DONE: begin
            if (start_go)                             state_d = S_RUN;
            else if (cmd_vld && (cmd == CMD_WRITE))   state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q == S_RUN);
      done_flag = (state_q == S_DONE);
   end

   always_comb begin
      case (op_sel)
         3'd0:    op_cur = op_q[0];
         3'd1:    op_cur = op_q[1];
         3'd2:    op_cur = op_q[2];
         3'd3:    op_cur = op_q[3];
         3'd4:    op_cur = op_q[4];
         3'd5:    op_cur = op_q[5];
         3'd6:    op_cur = op_q[6];
         default: op_cur = '0;
      endcase
   end

   assign res_sel = op_sel[0] ? res_z_q : res_w_q;

   // The top word is narrower than W; its unused wdata bits are dropped and read back as 0.
   for (genvar k = 0; k < NW; k++) begin : g_word
      localparam int LO = k * W;
      localparam int WB = ((M - LO) < W) ? (M - LO) : W;
      assign wr_val[LO +: WB] = (word_idx == 3'(k)) ? wdata[WB-1:0] : op_cur[LO +: WB];
      assign rd_words[k]      = W'(res_sel[LO +: WB]);
   end

   always_comb begin
      rd_word = '0;
      for (int k = 0; k < NW; k++)
         if (word_idx == 3'(k)) rd_word = rd_words[k];
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         req_s1  <= 1'b0;
         req_s2  <= 1'b0;
         req_s3  <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         start_q <= 1'b0;
         rdata_q <= '0;
         res_w_q <= '0;
         res_z_q <= '0;
         for (int i = 0; i < 7; i++) op_q[i] <= '0;
      end else begin
         req_s1  <= la_data_in[40];
         req_s2  <= req_s1;
         req_s3  <= req_s2;
         start_q <= start_go;
         if (cmd_vld) begin
            ack_q <= ~ack_q;
            if (nop_go)       err_q <= 1'b0;
            else if (cmd_err) err_q <= 1'b1;
         end
         if (wr_go)
            for (int i = 0; i < 7; i++)
               if (op_sel == 3'(i)) op_q[i] <= wr_val;
         if (rd_go) rdata_q <= rd_word;
         if (capture) begin
            res_w_q <= bec_wout;
            res_z_q <= bec_zout;
         end
      end
   end

   assign bec_start   = start_q;
   assign bec_w1      = op_q[0];
   assign bec_z1      = op_q[1];
   assign bec_w2      = op_q[2];
   assign bec_z2      = op_q[3];
   assign bec_inv_w0  = op_q[4];
   assign bec_d       = op_q[5];
   assign bec_key     = op_q[6];
   assign la_data_out = {{(58-W){1'b0}}, state_q, err_q, done_flag, busy, ack_q, rdata_q};

endmodule
